// File: rtl/mult_seq_ctrl.sv
// Sequencer for a shift-and-add multiplier datapath: load, conditional add, shift x WIDTH.
// Define EARLY_TERM_EN to finish as soon as the datapath multiplier register reaches zero.
module mult_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             q0,
  input  logic             mplr_zero,
  output logic             load,
  output logic             add_en,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  if (WIDTH < 2 || (2 ** CNT_W) <= WIDTH) begin : g_param_check
    $error("mult_seq_ctrl: need WIDTH >= 2 and 2**CNT_W > WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_nx;

`ifndef EARLY_TERM_EN
  logic unused_mplr_zero;
  assign unused_mplr_zero = mplr_zero;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = TEST;
      TEST: begin
`ifdef EARLY_TERM_EN
        if (mplr_zero)  state_nx = DONE;
        else if (q0)    state_nx = ADD;
        else            state_nx = SHIFT;
`else
        if (q0)         state_nx = ADD;
        else            state_nx = SHIFT;
`endif
      end
      ADD:     state_nx = SHIFT;
      SHIFT:   state_nx = (iter == LAST_ITER) ? DONE : TEST;
      DONE:    if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      iter     <= '0;
      load     <= 1'b0;
      add_en   <= 1'b0;
      shift_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      load     <= (state_nx == LOAD);
      add_en   <= (state_nx == ADD);
      shift_en <= (state_nx == SHIFT);
      busy     <= (state_nx == LOAD) || (state_nx == TEST) ||
                  (state_nx == ADD)  || (state_nx == SHIFT);
      done     <= (state_nx == DONE);
      // Clearing on entry to LOAD makes iter read 0 throughout the LOAD cycle.
      if (state_nx == LOAD)
        iter <= '0;
      else if (state == SHIFT)
        iter <= iter + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: a behavioural datapath closes the q0/mplr_zero loop,
// stimulus pushes hand-computed expectations, a negedge monitor pops them when done rises.
module tb_mult_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             q0;
  logic             mplr_zero;
  logic             load, add_en, shift_en, busy, done;
  logic [CNT_W-1:0] iter;

  mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q0(q0), .mplr_zero(mplr_zero),
    .load(load), .add_en(add_en), .shift_en(shift_en), .busy(busy), .done(done),
    .iter(iter)
  );

  always #5 clk = ~clk;

  // Behavioural datapath driven by the DUT enables.
  logic [2*WIDTH-1:0] acc = '0;
  logic [2*WIDTH-1:0] mcand = '0;
  logic [WIDTH-1:0]   mplr = '0;
  logic [WIDTH-1:0]   op_a = '0;
  logic [WIDTH-1:0]   op_b = '0;

  assign q0        = mplr[0];
  assign mplr_zero = (mplr == '0);

  always @(posedge clk) begin
    if (load) begin
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, op_a};
      mplr  <= op_b;
    end else begin
      if (add_en) acc <= acc + mcand;
      if (shift_en) begin
        mcand <= mcand << 1;
        mplr  <= mplr >> 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              lat;
    int              adds;
    int              shifts;
    int              it;
    logic [2*WIDTH-1:0] prod;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: per-cycle invariants, pulse counting, and scoreboard pop on done rising.
  initial begin : monitor
    int   launch, adds, shifts, loads;
    bit   pl, pd, ok;
    exp_t e;
    launch = 0; adds = 0; shifts = 0; loads = 0;
    pl = 1'b0; pd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        ok = ((int'(load) + int'(add_en) + int'(shift_en)) <= 1) && !(busy && done) &&
             (int'(iter) <= WIDTH);
        chk("exclusive", ok, 1);
        if (load) begin
          if (!pl) begin
            launch = cyc; adds = 0; shifts = 0; loads = 1;
          end else begin
            loads++;
          end
        end
        if (add_en) begin
          adds++;
          chk("add_needs_q0", mplr[0], 1);
        end
        if (shift_en) shifts++;
        if (done && !pd) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("latency", cyc - launch, e.lat);
            chk("load_pulses", loads, 1);
            chk("add_pulses", adds, e.adds);
            chk("shift_pulses", shifts, e.shifts);
            chk("iter_at_done", iter, e.it);
            chk("product", acc, e.prod);
          end
        end
      end
      pl = load;
      pd = done;
    end
  end

  task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input int lat, input int adds, input int shifts, input int it,
                     input logic [2*WIDTH-1:0] prod, input int mid);
    exp_t e;
    bit   got, pulsed;
    e.lat = lat; e.adds = adds; e.shifts = shifts; e.it = it; e.prod = prod;
    sb.push_back(e);
    op_a = a;
    op_b = b;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    // The cycle right after the launch edge is LOAD.
    chk("launch_done_low", done, 0);
    chk("launch_load", load, 1);
    chk("launch_iter", iter, 0);
    got = 1'b0;
    pulsed = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (mid >= 0 && !pulsed && busy && int'(iter) == mid) begin
        start = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic reset_mid_run();
    bit found;
    op_a = 8'h07;
    op_b = 8'hFF;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (shift_en && iter == 4'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) chk("reach_iter5_timeout", 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {load, add_en, shift_en, busy, done, iter}, 0);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle_busy", busy, 0);
    end
  endtask

  initial begin : stim
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("reset_idle", {load, add_en, shift_en, busy, done, iter}, 0);
    end

`ifdef EARLY_TERM_EN
    // 0x05: three shifts then a TEST that sees zero and goes straight to DONE (1+3+2+3+1 edges).
    run(8'h09, 8'h05, 10, 2, 3, 3, 16'd45, -1);
    run(8'h0B, 8'h00, 2, 0, 0, 0, 16'd0, -1);
    run(8'hFF, 8'hFF, 25, 8, 8, 8, 16'd65025, -1);
    reset_mid_run();
    run(8'h0B, 8'h5A, 20, 4, 7, 7, 16'd990, -1);
`else
    run(8'h3C, 8'hA5, 21, 4, 8, 8, 16'd9900, -1);
    run(8'hFF, 8'h00, 17, 0, 8, 8, 16'd0, -1);
    run(8'hFF, 8'hFF, 25, 8, 8, 8, 16'd65025, -1);
    run(8'h12, 8'h03, 19, 2, 8, 8, 16'd54, 3);
    reset_mid_run();
    run(8'h0B, 8'h5A, 21, 4, 8, 8, 16'd990, -1);
    run(8'h02, 8'h81, 19, 2, 8, 8, 16'd258, -1);
`endif

    repeat (3) @(negedge clk);
    chk("done_held", done, 1);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
